// File: rtl/ysyx_25040101_regfile_sb.sv
// Integer register file with write-to-read bypass and per-register busy scoreboard.
// Latency: reads are combinational (zero cycles); writes and busy updates take effect after posedge.
// Backpressure: none; busy flags are exported so the stall unit can hold decode.
module ysyx_25040101_regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int BYPASS = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 rs1_addr_i,
  input  logic [4:0]                 rs2_addr_i,
  output logic [XLEN-1:0]            rs1_data_o,
  output logic [XLEN-1:0]            rs2_data_o,
  output logic                       rs1_busy_o,
  output logic                       rs2_busy_o,
  input  logic                       wb_wen_i,
  input  logic [4:0]                 wb_addr_i,
  input  logic [XLEN-1:0]            wb_data_i,
  input  logic                       wb_clr_i,
  input  logic                       iss_valid_i,
  input  logic [4:0]                 iss_rd_i,
  output logic [$clog2(NREGS):0]     pend_cnt_o,
  output logic [NREGS*XLEN-1:0]      regs_flat_o
);

  localparam int CW = $clog2(NREGS) + 1;

  // Storage is sized to the full 5-bit address space so any address indexes
  // safely; entries at or above NREGS and entry 0 are never written.
  logic [XLEN-1:0] regs_q [32];
  logic [31:0]     busy_q;
  logic [31:0]     busy_nxt;
  logic [CW-1:0]   pend_q;

  logic wr_ok, clr_ok, iss_ok, set_inc, clr_dec;
  logic rs1_fwd, rs2_fwd;

  // x0 and addresses beyond the architectural count are not real registers.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a != 5'd0) && ({27'd0, a} < 32'(NREGS));
  endfunction

  assign wr_ok  = wb_wen_i && addr_ok(wb_addr_i);
  assign clr_ok = wr_ok && wb_clr_i;
  assign iss_ok = iss_valid_i && addr_ok(iss_rd_i);

  // Counter moves only on real idle->busy and busy->idle transitions; a
  // same-register issue+retire keeps the bit set, so it must not decrement.
  assign set_inc = iss_ok && !busy_q[iss_rd_i];
  assign clr_dec = clr_ok && busy_q[wb_addr_i] && !(iss_ok && (iss_rd_i == wb_addr_i));

  assign rs1_fwd = (BYPASS != 0) && wr_ok && (rs1_addr_i == wb_addr_i);
  assign rs2_fwd = (BYPASS != 0) && wr_ok && (rs2_addr_i == wb_addr_i);

  assign rs1_data_o = !addr_ok(rs1_addr_i) ? '0 : (rs1_fwd ? wb_data_i : regs_q[rs1_addr_i]);
  assign rs2_data_o = !addr_ok(rs2_addr_i) ? '0 : (rs2_fwd ? wb_data_i : regs_q[rs2_addr_i]);

  // A retiring writeback forwarded this cycle satisfies the dependency, so no stall.
  assign rs1_busy_o = addr_ok(rs1_addr_i) && busy_q[rs1_addr_i] && !(rs1_fwd && wb_clr_i);
  assign rs2_busy_o = addr_ok(rs2_addr_i) && busy_q[rs2_addr_i] && !(rs2_fwd && wb_clr_i);

  assign pend_cnt_o = pend_q;

  // Next busy vector: retire clears first, then a same-cycle issue re-sets (younger op wins).
  always_comb begin
    busy_nxt = busy_q;
    if (clr_ok) busy_nxt[wb_addr_i] = 1'b0;
    if (iss_ok) busy_nxt[iss_rd_i]  = 1'b1;
  end

  // Register file storage; reset clears every entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_ok) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

  // Scoreboard bits and pending counter; reset dominates issue and retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_nxt;
      pend_q <= pend_q + CW'(set_inc) - CW'(clr_dec);
    end
  end

  genvar g;
  generate
    for (g = 0; g < NREGS; g++) begin : g_flat
      assign regs_flat_o[g*XLEN +: XLEN] = regs_q[g];
    end
  endgenerate

endmodule

// File: tb/tb_ysyx_25040101_regfile_sb.sv
module tb_ysyx_25040101_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1_addr, rs2_addr, wb_addr, iss_rd;
  logic        wb_wen, wb_clr, iss_valid;
  logic [31:0] wb_data;

  // default: RV32I with bypass
  logic [31:0]   d_rs1, d_rs2;
  logic          d_b1, d_b2;
  logic [5:0]    d_pend;
  logic [1023:0] d_flat;
  // no bypass
  logic [31:0]   n_rs1, n_rs2;
  logic          n_b1, n_b2;
  logic [5:0]    n_pend;
  logic [1023:0] n_flat;
  // RV32E, 16 registers
  logic [31:0]   e_rs1, e_rs2;
  logic          e_b1, e_b2;
  logic [4:0]    e_pend;
  logic [511:0]  e_flat;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ysyx_25040101_regfile_sb u_dut (
    .clk(clk), .rst(rst), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(d_rs1), .rs2_data_o(d_rs2), .rs1_busy_o(d_b1), .rs2_busy_o(d_b2),
    .wb_wen_i(wb_wen), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_clr_i(wb_clr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .pend_cnt_o(d_pend), .regs_flat_o(d_flat)
  );

  ysyx_25040101_regfile_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) u_nb (
    .clk(clk), .rst(rst), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(n_rs1), .rs2_data_o(n_rs2), .rs1_busy_o(n_b1), .rs2_busy_o(n_b2),
    .wb_wen_i(wb_wen), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_clr_i(wb_clr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .pend_cnt_o(n_pend), .regs_flat_o(n_flat)
  );

  ysyx_25040101_regfile_sb #(.XLEN(32), .NREGS(16), .BYPASS(1)) u_e (
    .clk(clk), .rst(rst), .rs1_addr_i(rs1_addr), .rs2_addr_i(rs2_addr),
    .rs1_data_o(e_rs1), .rs2_data_o(e_rs2), .rs1_busy_o(e_b1), .rs2_busy_o(e_b2),
    .wb_wen_i(wb_wen), .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_clr_i(wb_clr),
    .iss_valid_i(iss_valid), .iss_rd_i(iss_rd), .pend_cnt_o(e_pend), .regs_flat_o(e_flat)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0; wb_wen = 1'b0; wb_clr = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    iss_valid = 1'b0; iss_rd = 5'd0;
  endtask

  // Advance one clock; inputs applied before the call are sampled at this posedge.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d, input logic clr);
    wb_wen = 1'b1; wb_addr = a; wb_data = d; wb_clr = clr;
  endtask

  task automatic issue(input logic [4:0] r);
    iss_valid = 1'b1; iss_rd = r;
  endtask

  initial begin
    idle();
    rs1_addr = 5'd0; rs2_addr = 5'd0;

    // 1: reset, everything reads zero
    rst = 1'b1;
    cyc();
    check("rst_pend", d_pend, 0);
    check("rst_pend_e", e_pend, 0);
    for (int i = 1; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i);
      #0.1;
      check($sformatf("rst_rs1_x%0d", i), d_rs1, 0);
      check($sformatf("rst_busy_x%0d", i), d_b2, 0);
    end
    wb(5'd0, 32'hDEADBEEF, 1'b0);
    cyc();
    rs1_addr = 5'd0; #1;
    check("x0_read", d_rs1, 0);
    check("x0_flat", d_flat[31:0], 0);

    // 2: bypass vs no bypass
    rs1_addr = 5'd5;
    wb(5'd5, 32'h12345678, 1'b0);
    #1;
    check("byp_rs1", d_rs1, 32'h12345678);
    check("nobyp_rs1", n_rs1, 0);
    check("byp_rs1_e", e_rs1, 32'h12345678);
    cyc();
    check("wr_rs1", d_rs1, 32'h12345678);
    check("wr_rs1_nb", n_rs1, 32'h12345678);
    check("wr_flat5", d_flat[5*32 +: 32], 32'h12345678);
    check("wr_flat5_e", e_flat[5*32 +: 32], 32'h12345678);

    // 3: issue, busy, retire with forwarding
    issue(5'd7);
    cyc();
    rs2_addr = 5'd7; #1;
    check("iss_busy7", d_b2, 1);
    check("iss_pend1", d_pend, 1);
    wb(5'd7, 32'h000000AA, 1'b1);
    #1;
    check("clr_busy7_byp", d_b2, 0);
    check("clr_data7_byp", d_rs2, 32'hAA);
    check("clr_busy7_nb", n_b2, 1);
    check("clr_data7_nb", n_rs2, 0);
    cyc();
    check("clr_pend0", d_pend, 0);
    check("clr_busy7_after", n_b2, 0);
    check("clr_data7_after", n_rs2, 32'hAA);

    // 4: same-register issue and retire keeps busy
    issue(5'd9);
    cyc();
    issue(5'd9);
    wb(5'd9, 32'h99, 1'b1);
    cyc();
    rs1_addr = 5'd9; #1;
    check("setclr_busy9", d_b1, 1);
    check("setclr_pend1", d_pend, 1);
    check("setclr_data9", d_rs1, 32'h99);
    wb(5'd9, 32'h9A, 1'b1);
    cyc();
    check("clr9_pend0", d_pend, 0);
    check("clr9_busy", d_b1, 0);

    // set and clear on different registers, idle clear, re-issue
    issue(5'd10);
    cyc();
    issue(5'd11);
    wb(5'd10, 32'h10, 1'b1);
    cyc();
    rs1_addr = 5'd10; rs2_addr = 5'd11; #1;
    check("diff_pend", d_pend, 1);
    check("diff_busy10", d_b1, 0);
    check("diff_busy11", d_b2, 1);
    wb(5'd12, 32'h12, 1'b1);
    cyc();
    check("idleclr_pend", d_pend, 1);
    issue(5'd11);
    cyc();
    check("reissue_pend", d_pend, 1);
    wb_clr = 1'b1; wb_addr = 5'd11;
    cyc();
    check("clr_no_wen_busy", d_b2, 1);
    check("clr_no_wen_pend", d_pend, 1);
    wb(5'd11, 32'h11, 1'b0);
    cyc();
    check("wen_no_clr_busy", d_b2, 1);
    check("wen_no_clr_data", d_rs2, 32'h11);
    wb(5'd11, 32'h11, 1'b1);
    cyc();
    check("clr11_pend0", d_pend, 0);

    // issue to x0 ignored
    issue(5'd0);
    cyc();
    rs1_addr = 5'd0; #1;
    check("x0_iss_pend", d_pend, 0);
    check("x0_busy", d_b1, 0);

    // 5: out-of-range register on RV32E
    wb(5'd20, 32'hFF, 1'b0);
    issue(5'd20);
    cyc();
    rs1_addr = 5'd20; #1;
    check("e_x20_data", e_rs1, 0);
    check("e_x20_busy", e_b1, 0);
    check("e_x20_pend", e_pend, 0);
    check("d_x20_data", d_rs1, 32'hFF);
    check("d_x20_pend", d_pend, 1);
    wb(5'd20, 32'hFF, 1'b1);
    cyc();
    check("d_x20_clr_pend", d_pend, 0);

    // 6: reset dominates issue and retire
    issue(5'd3);
    cyc();
    issue(5'd4);
    cyc();
    check("two_pend", d_pend, 2);
    rst = 1'b1;
    wb(5'd3, 32'h55, 1'b1);
    issue(5'd6);
    cyc();
    rs1_addr = 5'd3; rs2_addr = 5'd4; #1;
    check("rst2_pend", d_pend, 0);
    check("rst2_busy3", d_b1, 0);
    check("rst2_busy4", d_b2, 0);
    check("rst2_x3", d_rs1, 0);
    check("rst2_flat5", d_flat[5*32 +: 32], 0);
    rs1_addr = 5'd6; #1;
    check("rst2_busy6", d_b1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
